// File: rtl/ram_burst_pkg.sv
// rtl/ram_burst_pkg.sv - shared types and defaults for the RAM burst master
package ram_burst_pkg;

    localparam int AW_DEF = 7;
    localparam int DW_DEF = 8;
    localparam int LW_DEF = 8;
    localparam int RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/ram_burst_skid.sv
// rtl/ram_burst_skid.sv - 2-entry read output buffer with occupancy count
module ram_burst_skid #(
    parameter int DW = ram_burst_pkg::DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          push;
    logic          pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// rtl/ram_burst_master.sv - burst initiator for a single-port synchronous RAM
// Optional sticky address-wrap flag: RAM_BURST_MASTER_WRAP_ERR_EN.
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
`ifdef RAM_BURST_MASTER_WRAP_ERR_EN
    ,
    output logic          wrap_err
`endif
);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LW:0]       remain_q, remain_d;
    logic [RD_LAT-1:0] inflight_q;
    logic [1:0]        skid_count;
    logic              skid_in_ready;
    logic              cmd_hs, wr_beat, rd_pop, space_ok, issue, advance;
    logic              last_beat, drain_done;

    assign cmd_hs    = (state_q == IDLE) && cmd_valid;
    assign wr_beat   = (state_q == WRITE) && wr_valid;
    assign rd_pop    = rd_valid && rd_ready;
    // Reserve a buffer slot for every beat already on the RAM read port.
    assign space_ok  = (3'(skid_count) + 3'(inflight_q) - 3'(rd_pop)) < 3'd2;
    assign issue     = (state_q == READ) && space_ok && skid_in_ready;
    assign advance   = wr_beat || issue;
    assign last_beat = (remain_q == (LW+1)'(1));
    assign drain_done = (inflight_q == '0) &&
                        ((skid_count == 2'd0) || ((skid_count == 2'd1) && rd_pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = cmd_write ? WRITE : READ;
            WRITE:   if (wr_beat && last_beat) state_d = IDLE;
            READ:    if (issue && last_beat) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        wr_ready  = (state_q == WRITE);
        ram_we    = wr_beat;
        ram_wdata = wr_beat ? wr_data : '0;
        ram_addr  = addr_q;
    end

    always_comb begin
        addr_d   = addr_q;
        remain_d = remain_q;
        if (cmd_hs) begin
            addr_d   = cmd_addr;
            remain_d = (cmd_len == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, cmd_len};
        end else if (advance) begin
            addr_d   = addr_q + AW'(1);
            remain_d = remain_q - (LW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= '0;
        end else begin
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= RD_LAT'(issue);
        end
    end

`ifdef RAM_BURST_MASTER_WRAP_ERR_EN
    logic wrap_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_err_q <= 1'b0;
        end else if (cmd_hs) begin
            wrap_err_q <= 1'b0;
        end else if (advance && (addr_q == '1)) begin
            wrap_err_q <= 1'b1;
        end
    end

    assign wrap_err = wrap_err_q;
`endif

    ram_burst_skid #(.DW(DW)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (|inflight_q),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (ram_rdata),
        .out_valid_o (rd_valid),
        .out_ready_i (rd_ready),
        .out_data_o  (rd_data),
        .count_o     (skid_count)
    );

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator side of the 128x8 single-port synchronous RAM interface (we/addr/data_in in, data_out back).
- Accepts one burst command (start address, length, direction) and drives the RAM pins sequentially.
- Write bursts take bytes from an input stream; read bursts return bytes on an output stream with backpressure.
- Sits between a processing datapath and the RAM, replacing hand-driven we/addr sequencing.

Parameters:
- AW, 7, RAM address width (depth 2^AW).
- DW, 8, RAM data width.
- LW, 8, burst length field width; length 0 means 2^LW beats.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start address
- cmd_len  in  LW  beat count (0 = 2^LW)
- wr_valid  in  1  write byte offered
- wr_ready  out  1  write byte accepted this cycle
- wr_data  in  DW  write byte
- rd_valid  out  1  read byte available
- rd_ready  in  1  consumer accepts read byte
- rd_data  out  DW  read byte
- busy  out  1  burst in progress
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, registered by RAM (valid 1 cycle after address)

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_ready=1, busy=0, wr_ready=0, rd_valid=0, ram_we=0, ram_addr=0, ram_wdata=0, rd_data=0, counters 0.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On cmd handshake, latch addr/len/dir; go to WRITE or READ next cycle; busy=1 from the next cycle.
- WRITE: wr_ready=1. Each cycle with wr_valid=1: ram_we=1, ram_addr=current addr, ram_wdata=wr_data combinationally from inputs (same-cycle write), addr+1, remaining-1. wr_valid=0 leaves ram_we=0 (no write, no advance). Last beat returns to IDLE next cycle.
- READ: issue address only while the 2-entry output buffer has space for the in-flight beat. Data returns 1 cycle later and is captured into the buffer. After the last address is issued, go to DRAIN.
- DRAIN: wait for the final in-flight beat and for the buffer to empty, then go to IDLE.
- Read throughput: full rate (1 byte/cycle) when rd_ready is held high. Latency from cmd handshake to first rd_valid is 3 cycles.
- rd_valid/rd_data obey valid/ready: once asserted, they hold stable until rd_ready. No byte is lost or duplicated under any rd_ready pattern.
- Address arithmetic is modulo 2^AW: 127+1 wraps to 0.
- Length 0 means 256 beats, so a 256-beat burst over a 128-deep RAM touches every address twice.
- cmd_valid while busy is ignored (cmd_ready=0).
- rd_ready during a write burst has no effect. wr_valid during a read burst or in IDLE is ignored (wr_ready=0).
- rst_n asserted mid-burst aborts immediately: outputs go to reset values and the buffered read data is discarded.
- ram_we is never 1 outside WRITE.

Optional Feature:
- Macro: RAM_BURST_MASTER_WRAP_ERR_EN.
- Defined: adds output wrap_err (1 bit, reset 0). It is set sticky when a burst's address wraps past 2^AW-1. It is cleared only on the next cmd handshake. The burst still completes with wrapped addresses.
- Undefined: no port; wrap is silent.

Decomposition:
- Shared package ram_burst_pkg holds:
  - state enum {IDLE, WRITE, READ, DRAIN};
  - default AW/DW/LW localparams;
  - RD_LAT=1 constant.
- One natural sub-module: ram_burst_skid, the 2-entry read output buffer (valid/ready in, valid/ready out, occupancy count). The master instantiates it.

Test Plan:
- Write burst addr=10, len=2, data 0xAA,0x55 with wr_valid held high -> ram_we high for exactly 2 cycles at addrs 10,11; then read burst addr=10, len=2 -> rd_data 0xAA then 0x55.
- Read burst addr=20, len=4 with rd_ready=1 -> first rd_valid 3 cycles after handshake, then 4 consecutive beats in address order, busy falls after the last beat.
- Same read with rd_ready toggling 1,0,0,1,... -> all 4 bytes delivered once, in order, rd_data stable while rd_valid && !rd_ready.
- Write burst addr=126, len=4 -> writes land at 126,127,0,1; with macro defined, wrap_err=1 after the burst.
- rst_n pulled low for 1 cycle mid-read (after beat 2 of 8) -> rd_valid=0, cmd_ready=1, ram_we=0 immediately; a new command is accepted afterward.
- Write burst with wr_valid gaps (pattern 1,0,1,1) -> exactly 3 RAM writes; cmd_valid pulsed during the burst is not accepted.
